// File: rtl/axi_lite_master_cmdq_if.sv
// rtl/axi_lite_master_cmdq_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi_lite_master_cmdq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_master_cmdq.sv
// rtl/axi_lite_master_cmdq.sv - AXI4-Lite master fed by independent write/read command queues
module axi_lite_master_cmdq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          wr_cmd_valid,
  output logic                          wr_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]         wr_cmd_addr,
  input  logic [DATA_WIDTH-1:0]         wr_cmd_data,
  input  logic [DATA_WIDTH/8-1:0]       wr_cmd_strb,
  output logic                          wr_rsp_valid,
  output logic [1:0]                    wr_rsp,
  output logic [$clog2(CMD_DEPTH):0]    wr_level,
  output logic                          wr_timeout,
  input  logic                          rd_cmd_valid,
  output logic                          rd_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]         rd_cmd_addr,
  output logic                          rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]         rd_rsp_data,
  output logic [1:0]                    rd_rsp,
  output logic [$clog2(CMD_DEPTH):0]    rd_level,
  output logic                          rd_timeout,
  axi_lite_master_cmdq_if.master        m_axi
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {W_IDLE, W_BOTH, W_ADDR, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

  // write command queue
  logic [ADDR_WIDTH-1:0] wq_addr [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] wq_data [CMD_DEPTH];
  logic [SW-1:0]         wq_strb [CMD_DEPTH];
  logic [PW-1:0]         wq_wp, wq_rp;
  logic [LW-1:0]         wq_cnt;
  logic                  wr_push, wr_pop;

  // read command queue
  logic [ADDR_WIDTH-1:0] rq_addr [CMD_DEPTH];
  logic [PW-1:0]         rq_wp, rq_rp;
  logic [LW-1:0]         rq_cnt;
  logic                  rd_push, rd_pop;

  // AXI-side registered state
  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  assign wr_cmd_ready = (wq_cnt != LW'(CMD_DEPTH));
  assign rd_cmd_ready = (rq_cnt != LW'(CMD_DEPTH));
  assign wr_push      = wr_cmd_valid && wr_cmd_ready;
  assign rd_push      = rd_cmd_valid && rd_cmd_ready;
  assign wr_pop       = (wr_state == W_IDLE) && (wq_cnt != '0);
  assign rd_pop       = (rd_state == R_IDLE) && (rq_cnt != '0);
  assign wr_level     = wq_cnt;
  assign rd_level     = rq_cnt;

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  // queue storage is written only on push, so it needs no reset
  always_ff @(posedge aclk) begin
    if (wr_push) begin
      wq_addr[wq_wp] <= wr_cmd_addr;
      wq_data[wq_wp] <= wr_cmd_data;
      wq_strb[wq_wp] <= wr_cmd_strb;
    end
    if (rd_push) begin
      rq_addr[rq_wp] <= rd_cmd_addr;
    end
  end

  // queue pointers and occupancy; pointers wrap naturally since depth is a power of 2
  always_ff @(posedge aclk) begin
    if (areset) begin
      wq_wp  <= '0;
      wq_rp  <= '0;
      wq_cnt <= '0;
      rq_wp  <= '0;
      rq_rp  <= '0;
      rq_cnt <= '0;
    end else begin
      if (wr_push) wq_wp <= wq_wp + 1'b1;
      if (wr_pop)  wq_rp <= wq_rp + 1'b1;
      case ({wr_push, wr_pop})
        2'b10:   wq_cnt <= wq_cnt + 1'b1;
        2'b01:   wq_cnt <= wq_cnt - 1'b1;
        default: wq_cnt <= wq_cnt;
      endcase
      if (rd_push) rq_wp <= rq_wp + 1'b1;
      if (rd_pop)  rq_rp <= rq_rp + 1'b1;
      case ({rd_push, rd_pop})
        2'b10:   rq_cnt <= rq_cnt + 1'b1;
        2'b01:   rq_cnt <= rq_cnt - 1'b1;
        default: rq_cnt <= rq_cnt;
      endcase
    end
  end

  // write FSM: AW and W issued together, each valid dropped on its own handshake
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state     <= W_IDLE;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      wr_rsp_valid <= 1'b0;
      wr_rsp       <= 2'b00;
    end else begin
      wr_rsp_valid <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (wr_pop) begin
            awaddr_q  <= wq_addr[wq_rp];
            wdata_q   <= wq_data[wq_rp];
            wstrb_q   <= wq_strb[wq_rp];
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            wr_state  <= W_BOTH;
          end
        end
        W_BOTH: begin
          if (m_axi.awready && m_axi.wready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b1;
            wr_state  <= W_RESP;
          end else if (m_axi.awready) begin
            awvalid_q <= 1'b0;
            wr_state  <= W_DATA;
          end else if (m_axi.wready) begin
            wvalid_q  <= 1'b0;
            wr_state  <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (m_axi.awready) begin
            awvalid_q <= 1'b0;
            bready_q  <= 1'b1;
            wr_state  <= W_RESP;
          end
        end
        W_DATA: begin
          if (m_axi.wready) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_axi.bvalid) begin
            bready_q     <= 1'b0;
            wr_rsp_valid <= 1'b1;
            wr_rsp       <= m_axi.bresp;
            wr_state     <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // read FSM: rready is asserted only while waiting for R
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state     <= R_IDLE;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
      rd_rsp       <= 2'b00;
    end else begin
      rd_rsp_valid <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (rd_pop) begin
            araddr_q  <= rq_addr[rq_rp];
            arvalid_q <= 1'b1;
            rd_state  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            rd_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_axi.rvalid) begin
            rready_q     <= 1'b0;
            rd_rsp_valid <= 1'b1;
            rd_rsp_data  <= m_axi.rdata;
            rd_rsp       <= m_axi.rresp;
            rd_state     <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  logic wr_hs, wr_wait, rd_hs, rd_wait;

  assign wr_hs   = (awvalid_q && m_axi.awready) || (wvalid_q && m_axi.wready) ||
                   (bready_q && m_axi.bvalid);
  assign wr_wait = (awvalid_q && !m_axi.awready) || (wvalid_q && !m_axi.wready) ||
                   (bready_q && !m_axi.bvalid);
  assign rd_hs   = (arvalid_q && m_axi.arready) || (rready_q && m_axi.rvalid);
  assign rd_wait = (arvalid_q && !m_axi.arready) || (rready_q && !m_axi.rvalid);

  generate
    if (TIMEOUT > 0) begin : g_wdog
      logic [TW-1:0] wr_wd_cnt, rd_wd_cnt;

      // per-channel stall counters; flags are sticky and never abort the transfer
      always_ff @(posedge aclk) begin
        if (areset) begin
          wr_wd_cnt  <= '0;
          rd_wd_cnt  <= '0;
          wr_timeout <= 1'b0;
          rd_timeout <= 1'b0;
        end else begin
          if (wr_hs) begin
            wr_wd_cnt <= '0;
          end else if (wr_wait && (wr_wd_cnt != TW'(TIMEOUT))) begin
            wr_wd_cnt <= wr_wd_cnt + 1'b1;
            if (wr_wd_cnt == TW'(TIMEOUT - 1)) wr_timeout <= 1'b1;
          end
          if (rd_hs) begin
            rd_wd_cnt <= '0;
          end else if (rd_wait && (rd_wd_cnt != TW'(TIMEOUT))) begin
            rd_wd_cnt <= rd_wd_cnt + 1'b1;
            if (rd_wd_cnt == TW'(TIMEOUT - 1)) rd_timeout <= 1'b1;
          end
        end
      end
    end else begin : g_no_wdog
      assign wr_timeout = 1'b0;
      assign rd_timeout = 1'b0;
    end
  endgenerate

endmodule
